// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline slice: load access-size encodings
// and the default datapath/register-file widths.
package mips_pkg;

    localparam int DEFAULT_DATA_WIDTH    = 32;
    localparam int DEFAULT_RF_ADDR_WIDTH = 5;

    // The 2'b11 encoding is not a real access size; it behaves as a word.
    typedef enum logic [1:0] {
        SEL_WORD     = 2'b00,
        SEL_HALF     = 2'b01,
        SEL_BYTE     = 2'b10,
        SEL_WORD_ALT = 2'b11
    } ram_sel_e;

endpackage

// File: rtl/writeback_stage_load_formatter.sv
// Combinational little-endian load formatter: extracts the addressed byte or
// half from the RAM word, sign/zero-extends it and flags misaligned loads.
module load_formatter
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic [1:0]            byte_addr,
    input  logic [1:0]            ram_sel,
    input  logic                  load_unsigned,
    input  logic                  mem_to_reg,
    input  logic                  valid,
    output logic [DATA_WIDTH-1:0] formatted,
    output logic                  misalign
);

    ram_sel_e   sel;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    assign sel = ram_sel_e'(ram_sel);

    always_comb begin
        byte_val = 8'h00;
        case (byte_addr)
            2'd0:    byte_val = read_data[7:0];
            2'd1:    byte_val = read_data[15:8];
            2'd2:    byte_val = read_data[23:16];
            default: byte_val = read_data[31:24];
        endcase
        half_val = byte_addr[1] ? read_data[31:16] : read_data[15:0];

        formatted = read_data;
        misalign  = 1'b0;
        case (sel)
            SEL_BYTE: begin
                formatted = {{(DATA_WIDTH-8){byte_val[7] & ~load_unsigned}}, byte_val};
            end
            SEL_HALF: begin
                formatted = {{(DATA_WIDTH-16){half_val[15] & ~load_unsigned}}, half_val};
                misalign  = byte_addr[0];
            end
            default: begin
                misalign = (byte_addr != 2'b00);
            end
        endcase

        // Only a live load can be misaligned; ALU results reuse the address bus freely.
        if (!(mem_to_reg && valid)) begin
            misalign = 1'b0;
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// Memory-to-writeback pipeline register with load formatting, register-file
// write qualification and a retired-instruction counter.
module writeback_stage
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int RF_ADDR_WIDTH = DEFAULT_RF_ADDR_WIDTH
) (
    input  logic                     i_CLK,
    input  logic                     i_RST_n,
    input  logic [DATA_WIDTH-1:0]    i_ReadDataM,
    input  logic [DATA_WIDTH-1:0]    i_ALUOutM,
    input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegM,
    input  logic                     i_RegWriteM,
    input  logic                     i_MemtoRegM,
    input  logic                     i_LoadUnsignedM,
    input  logic                     i_ValidM,
    input  logic [1:0]               i_RAM_selM,
    input  logic                     i_StallW,
    input  logic                     i_FlushW,
    output logic [DATA_WIDTH-1:0]    o_ReadDataW,
    output logic [DATA_WIDTH-1:0]    o_ResultW,
    output logic [RF_ADDR_WIDTH-1:0] o_WriteRegW,
    output logic                     o_RegWriteW,
    output logic                     o_ValidW,
    output logic                     o_MisalignW,
    output logic [31:0]              o_RetiredCountW
);

    logic [DATA_WIDTH-1:0]    load_data;
    logic                     misalign;
    logic                     reg_write_next;

    logic [DATA_WIDTH-1:0]    read_data_q;
    logic [DATA_WIDTH-1:0]    alu_out_q;
    logic [RF_ADDR_WIDTH-1:0] write_reg_q;
    logic                     reg_write_q;
    logic                     mem_to_reg_q;
    logic                     valid_q;
    logic                     misalign_q;
    logic [31:0]              retired_count;

    load_formatter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_formatter (
        .read_data    (i_ReadDataM),
        .byte_addr    (i_ALUOutM[1:0]),
        .ram_sel      (i_RAM_selM),
        .load_unsigned(i_LoadUnsignedM),
        .mem_to_reg   (i_MemtoRegM),
        .valid        (i_ValidM),
        .formatted    (load_data),
        .misalign     (misalign)
    );

    // Writes to $zero and faulting loads must never reach the register file.
    assign reg_write_next = i_RegWriteM & i_ValidM & ~misalign & (i_WriteRegM != '0);

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            read_data_q   <= '0;
            alu_out_q     <= '0;
            write_reg_q   <= '0;
            reg_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            valid_q       <= 1'b0;
            misalign_q    <= 1'b0;
            retired_count <= '0;
        end else if (i_FlushW) begin
            read_data_q   <= '0;
            alu_out_q     <= '0;
            write_reg_q   <= '0;
            reg_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            valid_q       <= 1'b0;
            misalign_q    <= 1'b0;
        end else if (!i_StallW) begin
            read_data_q   <= load_data;
            alu_out_q     <= i_ALUOutM;
            write_reg_q   <= i_WriteRegM;
            reg_write_q   <= reg_write_next;
            mem_to_reg_q  <= i_MemtoRegM;
            valid_q       <= i_ValidM;
            misalign_q    <= misalign;
            if (i_ValidM && !misalign) begin
                retired_count <= retired_count + 32'd1;
            end
        end
    end

    assign o_ReadDataW     = read_data_q;
    assign o_ResultW       = mem_to_reg_q ? read_data_q : alu_out_q;
    assign o_WriteRegW     = write_reg_q;
    assign o_RegWriteW     = reg_write_q;
    assign o_ValidW        = valid_q;
    assign o_MisalignW     = misalign_q;
    assign o_RetiredCountW = retired_count;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomised and directed bench for writeback_stage, checked every cycle
// against a transaction-level model of what the W stage must hold.
module tb_writeback_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] read_data_m;
    logic [31:0] alu_out_m;
    logic [4:0]  write_reg_m;
    logic        reg_write_m;
    logic        mem_to_reg_m;
    logic        load_unsigned_m;
    logic        valid_m;
    logic [1:0]  ram_sel_m;
    logic        stall_w;
    logic        flush_w;

    logic [31:0] read_data_w;
    logic [31:0] result_w;
    logic [4:0]  write_reg_w;
    logic        reg_write_w;
    logic        valid_w;
    logic        misalign_w;
    logic [31:0] retired_count_w;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [31:0] read_data;
        logic [31:0] result;
        logic [4:0]  wreg;
        logic        reg_write;
        logic        valid;
        logic        misalign;
    } wb_t;

    wb_t         m_wb;
    logic [31:0] m_count;
    logic [31:0] count_bias;

    writeback_stage #(
        .DATA_WIDTH(32),
        .RF_ADDR_WIDTH(5)
    ) dut (
        .i_CLK          (clk),
        .i_RST_n        (rst_n),
        .i_ReadDataM    (read_data_m),
        .i_ALUOutM      (alu_out_m),
        .i_WriteRegM    (write_reg_m),
        .i_RegWriteM    (reg_write_m),
        .i_MemtoRegM    (mem_to_reg_m),
        .i_LoadUnsignedM(load_unsigned_m),
        .i_ValidM       (valid_m),
        .i_RAM_selM     (ram_sel_m),
        .i_StallW       (stall_w),
        .i_FlushW       (flush_w),
        .o_ReadDataW    (read_data_w),
        .o_ResultW      (result_w),
        .o_WriteRegW    (write_reg_w),
        .o_RegWriteW    (reg_write_w),
        .o_ValidW       (valid_w),
        .o_MisalignW    (misalign_w),
        .o_RetiredCountW(retired_count_w)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] format_load(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] sel, input logic uns);
        int unsigned w;
        int unsigned v;
        w = word;
        if (sel == SEL_BYTE) begin
            v = (w >> (8 * int'(lane))) & 32'hFF;
            if (!uns && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sel == SEL_HALF) begin
            v = (w >> (16 * int'(lane[1]))) & 32'hFFFF;
            if (!uns && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic misaligned(input logic m2r, input logic valid, input logic [1:0] sel,
                                        input logic [1:0] lane);
        if (!(m2r && valid)) return 1'b0;
        if (sel == SEL_HALF) return lane[0];
        if (sel == SEL_BYTE) return 1'b0;
        return lane != 2'b00;
    endfunction

    function automatic wb_t from_mem(input logic [31:0] rdata, input logic [31:0] alu,
                                     input logic [4:0] wreg, input logic rw, input logic m2r,
                                     input logic uns, input logic valid, input logic [1:0] sel);
        wb_t e;
        logic mis;
        logic [31:0] ld;
        mis = misaligned(m2r, valid, sel, alu[1:0]);
        ld  = format_load(rdata, alu[1:0], sel, uns);
        e.read_data = ld;
        e.result    = m2r ? ld : alu;
        e.wreg      = wreg;
        e.reg_write = rw && valid && !mis && (wreg != 5'd0);
        e.valid     = valid;
        e.misalign  = mis;
        return e;
    endfunction

    // Reference model: what the W stage must present after each edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wb    <= '0;
            m_count <= 32'd0;
        end else if (flush_w) begin
            m_wb <= '0;
        end else if (!stall_w) begin
            m_wb <= from_mem(read_data_m, alu_out_m, write_reg_m, reg_write_m, mem_to_reg_m,
                             load_unsigned_m, valid_m, ram_sel_m);
            if (valid_m && !misaligned(mem_to_reg_m, valid_m, ram_sel_m, alu_out_m[1:0]))
                m_count <= m_count + 32'd1;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check_output("read_data", read_data_w, m_wb.read_data);
        check_output("result", result_w, m_wb.result);
        check_output("write_reg", 32'(write_reg_w), 32'(m_wb.wreg));
        check_output("reg_write", 32'(reg_write_w), 32'(m_wb.reg_write));
        check_output("valid", 32'(valid_w), 32'(m_wb.valid));
        check_output("misalign", 32'(misalign_w), 32'(m_wb.misalign));
        check_output("retired_count", retired_count_w, m_count + count_bias);
    endtask

    // Drive one instruction from just after a falling edge, then check at the next falling edge.
    task automatic apply_stimulus(input logic stall, input logic flush, input logic valid,
                                  input logic rw, input logic m2r, input logic uns,
                                  input logic [1:0] sel, input logic [4:0] wreg,
                                  input logic [31:0] alu, input logic [31:0] rdata);
        stall_w         = stall;
        flush_w         = flush;
        valid_m         = valid;
        reg_write_m     = rw;
        mem_to_reg_m    = m2r;
        load_unsigned_m = uns;
        ram_sel_m       = sel;
        write_reg_m     = wreg;
        alu_out_m       = alu;
        read_data_m     = rdata;
        @(negedge clk);
        compare_model();
    endtask

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            apply_stimulus($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                           1'($urandom), 1'($urandom), 2'($urandom), 5'($urandom),
                           $urandom, $urandom);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_read_data"}, read_data_w, 32'd0);
        check_output({tag, "_result"}, result_w, 32'd0);
        check_output({tag, "_write_reg"}, 32'(write_reg_w), 32'd0);
        check_output({tag, "_reg_write"}, 32'(reg_write_w), 32'd0);
        check_output({tag, "_valid"}, 32'(valid_w), 32'd0);
        check_output({tag, "_misalign"}, 32'(misalign_w), 32'd0);
        check_output({tag, "_count"}, retired_count_w, 32'd0);
    endtask

    localparam logic [31:0] WORD = 32'h11F2_3384;

    initial begin
        count_bias = 32'd0;
        stall_w = 1'b0; flush_w = 1'b0; valid_m = 1'b0; reg_write_m = 1'b0;
        mem_to_reg_m = 1'b0; load_unsigned_m = 1'b0; ram_sel_m = 2'b00;
        write_reg_m = 5'd0; alu_out_m = 32'd0; read_data_m = 32'd0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        compare_model();
        rst_n = 1'b1;

        // Byte loads, signed
        apply_stimulus(0, 0, 1, 1, 1, 0, 2'b10, 5'd5, 32'h0000_1001, WORD);
        check_output("byte_lane1", read_data_w, 32'h0000_0033);
        check_output("byte_lane1_result", result_w, 32'h0000_0033);
        check_output("count_1", retired_count_w, 32'd1);
        apply_stimulus(0, 0, 1, 1, 1, 0, 2'b10, 5'd5, 32'h0000_1002, WORD);
        check_output("byte_lane2_sext", read_data_w, 32'hFFFF_FFF2);
        check_output("count_2", retired_count_w, 32'd2);

        // Half loads: aligned unsigned, then misaligned
        apply_stimulus(0, 0, 1, 1, 1, 1, 2'b01, 5'd6, 32'h0000_1002, WORD);
        check_output("half_upper_uns", read_data_w, 32'h0000_11F2);
        check_output("count_3", retired_count_w, 32'd3);
        apply_stimulus(0, 0, 1, 1, 1, 1, 2'b01, 5'd6, 32'h0000_1001, WORD);
        check_output("half_misalign", 32'(misalign_w), 32'd1);
        check_output("half_misalign_rw", 32'(reg_write_w), 32'd0);
        check_output("half_misalign_count", retired_count_w, 32'd3);

        // Stall three cycles with a new instruction waiting
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 0, 1, 1, 0, 0, 2'b00, 5'd7, 32'hABCD_0000, 32'h0);
            check_output("stall_hold_count", retired_count_w, 32'd3);
            check_output("stall_hold_misalign", 32'(misalign_w), 32'd1);
        end
        apply_stimulus(0, 0, 1, 1, 0, 0, 2'b00, 5'd7, 32'hABCD_0000, 32'h0);
        check_output("release_result", result_w, 32'hABCD_0000);
        check_output("release_count", retired_count_w, 32'd4);
        check_output("release_rw", 32'(reg_write_w), 32'd1);

        // Flush and stall on the same edge
        apply_stimulus(1, 1, 1, 1, 0, 0, 2'b00, 5'd9, 32'h1234_5678, 32'h0);
        check_output("flush_valid", 32'(valid_w), 32'd0);
        check_output("flush_rw", 32'(reg_write_w), 32'd0);
        check_output("flush_count", retired_count_w, 32'd4);

        // Write to $zero still retires
        apply_stimulus(0, 0, 1, 1, 0, 0, 2'b00, 5'd0, 32'h0000_0042, 32'h0);
        check_output("reg0_rw", 32'(reg_write_w), 32'd0);
        check_output("reg0_valid", 32'(valid_w), 32'd1);
        check_output("reg0_count", retired_count_w, 32'd5);

        // Counter wrap from a preset all-ones value
        force dut.retired_count = 32'hFFFF_FFFF;
        #1 release dut.retired_count;
        count_bias = 32'hFFFF_FFFF - m_count;
        apply_stimulus(0, 0, 1, 1, 0, 0, 2'b00, 5'd3, 32'h0000_0010, 32'h0);
        check_output("count_wrap", retired_count_w, 32'd0);

        random_cycles(1500);

        // Asynchronous reset between edges while streaming
        @(posedge clk);
        #2 rst_n = 1'b0;
        count_bias = 32'd0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        compare_model();
        rst_n = 1'b1;
        apply_stimulus(0, 0, 1, 1, 0, 0, 2'b00, 5'd4, 32'h0000_0100, 32'h0);
        check_output("count_restart", retired_count_w, 32'd1);

        // Reset while stalled discards the held instruction
        apply_stimulus(1, 0, 1, 1, 0, 0, 2'b00, 5'd8, 32'h0000_0200, 32'h0);
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 32'h0, 32'h0);
        check_output("reset_stall_valid", 32'(valid_w), 32'd0);
        check_output("reset_stall_count", retired_count_w, 32'd0);

        random_cycles(500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
